// File: rtl/fact_mmio_responder_pkg.sv
// Shared definitions for the factorial MMIO responder: window defaults,
// register offsets and accelerator FSM state encoding.
package fact_mmio_responder_pkg;

    // Peripheral window base (16-byte window) and largest n whose n! fits in 32 bits.
    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0800;
    localparam int unsigned NMAX_DEFAULT      = 12;

    // Word offsets inside the window, taken from a[3:2].
    localparam logic [1:0] OFF_N    = 2'd0;
    localparam logic [1:0] OFF_GO   = 2'd1;
    localparam logic [1:0] OFF_STAT = 2'd2;
    localparam logic [1:0] OFF_RES  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2
    } fact_state_t;

endpackage

// File: rtl/fact_core.sv
// Iterative factorial engine: on go, loads n, multiplies acc by a falling
// counter one step per cycle, and publishes result/done/err on completion.
module fact_core
    import fact_mmio_responder_pkg::*;
#(
    parameter int unsigned NMAX = NMAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [3:0]  n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result
);

    localparam logic [3:0] NMAX_N = 4'(NMAX);

    fact_state_t state, state_n;
    logic [31:0] acc, acc_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] result_q, result_n;
    logic        done_q, done_n;
    logic        err_q, err_n;

    // Next-state and next-datapath values for the accelerator FSM.
    always_comb begin
        // NOTE: every next value is defaulted to its current value first, so no
        // branch leaves one unassigned and no latch is inferred.
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        result_n = result_q;
        done_n   = done_q;
        err_n    = err_q;
        case (state)
            IDLE: begin
                if (go) begin
                    state_n = LOAD;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                end
            end
            LOAD: begin
                cnt_n = n;
                acc_n = 32'd1;
                if (n > NMAX_N) begin
                    // Result would overflow 32 bits: flag and finish immediately.
                    err_n    = 1'b1;
                    done_n   = 1'b1;
                    result_n = 32'd0;
                    state_n  = IDLE;
                end else begin
                    state_n = MULT;
                end
            end
            MULT: begin
                if (cnt <= 4'd1) begin
                    result_n = acc;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end else begin
                    // 32x4 unsigned multiply; only the low 32 bits are kept.
                    acc_n = acc * {28'd0, cnt};
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any computation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= 32'd0;
            cnt      <= 4'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register updates from the values present before the edge.
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            result_q <= result_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    assign busy   = (state != IDLE);
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: rtl/fact_mmio_responder.sv
// Data-port responder between the core and dmem: decodes a 16-byte
// peripheral window hosting the factorial accelerator and passes every other
// address through to data memory.
module fact_mmio_responder
    import fact_mmio_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
    parameter int unsigned NMAX      = NMAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        dmem_we,
    input  logic [31:0] dmem_rd,
    output logic        busy
);

    logic        sel;
    logic [1:0]  off;
    logic [3:0]  n_q;
    logic        go;
    logic        done;
    logic        err;
    logic [31:0] result;

    assign sel     = (a[31:4] == BASE_ADDR[31:4]);
    assign off     = a[3:2];
    assign dmem_we = we & ~sel;

    // Byte-lane bits and upper write-data bits have no meaning in this window.
    logic unused_ok;
    assign unused_ok = &{1'b0, a[1:0], wd[31:4]};

    // A GO write only starts the engine when it is idle.
    assign go = we & sel & (off == OFF_GO) & wd[0] & ~busy;

    // N register; writes while the engine is busy are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q <= 4'd0;
        end else if (we && sel && (off == OFF_N) && !busy) begin
            n_q <= wd[3:0];
        end
    end

    fact_core #(
        .NMAX (NMAX)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .n      (n_q),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    // Read mux: peripheral register inside the window, data memory outside.
    always_comb begin
        rd = dmem_rd;
        if (sel) begin
            case (off)
                OFF_N:    rd = {28'd0, n_q};
                OFF_GO:   rd = 32'd0;
                OFF_STAT: rd = {30'd0, err, done};
                OFF_RES:  rd = result;
                default:  rd = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_mmio_responder.sv
// Self-checking bench for fact_mmio_responder: directed and randomized
// factorial jobs against a plain-arithmetic reference, reset, busy and
// pass-through scenarios.
module tb_fact_mmio_responder;

    localparam logic [31:0] A_N   = 32'h0000_0800;
    localparam logic [31:0] A_GO  = 32'h0000_0804;
    localparam logic [31:0] A_ST  = 32'h0000_0808;
    localparam logic [31:0] A_RES = 32'h0000_080C;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        dmem_we;
    logic [31:0] dmem_rd;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    fact_mmio_responder dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .a       (a),
        .wd      (wd),
        .rd      (rd),
        .dmem_we (dmem_we),
        .dmem_rd (dmem_rd),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference: n! computed directly, 0 when it would not fit in 32 bits.
    function automatic logic [31:0] ref_fact(input int n);
        logic [31:0] r;
        if (n > 12) return 32'd0;
        r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    // Reference: edges from the GO-write edge until done is visible.
    function automatic int ref_edges(input int n);
        if (n > 12) return 1;
        if (n < 1) return 2;
        return n + 1;
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1; a = addr; wd = data;
        @(posedge clk);
        #1;
        we = 1'b0; a = 32'h0; wd = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        we = 1'b0; a = addr;
        #1;
        data = rd;
    endtask

    // Issues N then GO; returns edges until done (-1 if the bound expires)
    // and the busy level sampled just after the GO edge.
    task automatic start_job(input int n, output int edges, output logic busy_after_go);
        logic [31:0] s;
        bus_write(A_N, 32'(n));
        bus_write(A_GO, 32'h1);
        busy_after_go = busy;
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            bus_read(A_ST, s);
            if (s[0]) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        int          e;
        logic        b;
        reset = 1'b0; we = 1'b0; a = 32'h0; wd = 32'h0; dmem_rd = 32'h0;
        #2;
        bus_read(A_ST, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", v, 32'd0); end
        bus_read(A_RES, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=%h", v, 32'd0); end
        @(negedge clk); #2 reset = 1'b1;
        // Abort a job mid-MULT: N=7, GO, then three more edges.
        bus_write(A_N, 32'd7);
        bus_write(A_GO, 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk); #2 reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_busy got=%b exp=0", busy); end
        bus_read(A_ST, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL midrun_reset_status got=%h exp=0", v); end
        bus_read(A_RES, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL midrun_reset_result got=%h exp=0", v); end
        bus_read(A_N, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL midrun_reset_n got=%h exp=0", v); end
        dmem_rd = 32'hDEAD_BEEF;
        bus_read(32'h0000_0010, v);
        n_checks++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reset_passthru_rd got=%h exp=deadbeef", v); end
        @(negedge clk); #2 reset = 1'b1;
        // Nothing may resume after reset is released.
        repeat (4) @(posedge clk);
        #1;
        bus_read(A_ST, v);
        n_checks++; if (busy !== 1'b0 || v !== 32'd0) begin n_fail++; $display("FAIL post_reset_idle busy=%b status=%h exp busy=0 status=0", busy, v); end
        // Quiet unused-variable warnings for the helper outputs in this task.
        e = 0; b = 1'b0;
        if (e != 0 || b) $display("unexpected");
    endtask

    task automatic test_factorial();
        int          list[$];
        int          e;
        logic        b;
        logic [31:0] v;
        list = '{5, 0, 1, 12};
        for (int i = 0; i < 8; i++) list.push_back(int'($urandom_range(0, 15)));
        foreach (list[i]) begin
            start_job(list[i], e, b);
            n_checks++; if (b !== 1'b1) begin n_fail++; $display("FAIL busy_after_go n=%0d got=%b exp=1", list[i], b); end
            n_checks++; if (e != ref_edges(list[i])) begin n_fail++; $display("FAIL done_latency n=%0d got=%0d exp=%0d", list[i], e, ref_edges(list[i])); end
            bus_read(A_RES, v);
            n_checks++; if (v !== ref_fact(list[i])) begin n_fail++; $display("FAIL result n=%0d got=%h exp=%h", list[i], v, ref_fact(list[i])); end
            bus_read(A_ST, v);
            n_checks++; if (v !== {30'd0, (list[i] > 12), 1'b1}) begin n_fail++; $display("FAIL status n=%0d got=%h exp=%h", list[i], v, {30'd0, (list[i] > 12), 1'b1}); end
        end
    endtask

    task automatic test_error();
        int          e;
        logic        b;
        logic [31:0] v;
        start_job(13, e, b);
        n_checks++; if (e != 1) begin n_fail++; $display("FAIL err_latency got=%0d exp=1", e); end
        bus_read(A_ST, v);
        n_checks++; if (v !== 32'd3) begin n_fail++; $display("FAIL err_status got=%h exp=3", v); end
        bus_read(A_RES, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL err_result got=%h exp=0", v); end
        start_job(3, e, b);
        bus_read(A_ST, v);
        n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL err_cleared_status got=%h exp=1", v); end
        bus_read(A_RES, v);
        n_checks++; if (v !== 32'd6) begin n_fail++; $display("FAIL err_cleared_result got=%h exp=6", v); end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] v;
        int          e;
        bus_write(A_N, 32'd10);
        bus_write(A_GO, 32'h1);
        bus_write(A_N, 32'd2);
        bus_write(A_GO, 32'h1);
        e = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            bus_read(A_ST, v);
            if (v[0]) begin
                e = k;
                break;
            end
        end
        // Two write cycles already elapsed since the accepted GO edge.
        n_checks++; if (e + 2 != ref_edges(10)) begin n_fail++; $display("FAIL busy_latency got=%0d exp=%0d", e + 2, ref_edges(10)); end
        bus_read(A_RES, v);
        n_checks++; if (v !== ref_fact(10)) begin n_fail++; $display("FAIL busy_result got=%h exp=%h", v, ref_fact(10)); end
        bus_read(A_N, v);
        n_checks++; if (v !== 32'd10) begin n_fail++; $display("FAIL busy_n_kept got=%h exp=%h", v, 32'd10); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_restart got=%b exp=0", busy); end
    endtask

    task automatic test_passthrough();
        logic [31:0] v;
        logic [31:0] addr;
        logic        w;
        logic        in_win;
        @(negedge clk);
        we = 1'b1; a = 32'h0000_0804; wd = 32'h0;
        #1;
        n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL pt_window_we got=%b exp=0", dmem_we); end
        a = 32'h0000_0040;
        #1;
        n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL pt_dmem_we got=%b exp=1", dmem_we); end
        we = 1'b0;
        bus_read(A_RES, v);
        n_checks++; if (v !== ref_fact(10)) begin n_fail++; $display("FAIL pt_result_read got=%h exp=%h", v, ref_fact(10)); end
        bus_read(32'h0000_080E, v);
        n_checks++; if (v !== ref_fact(10)) begin n_fail++; $display("FAIL pt_result_bytelane got=%h exp=%h", v, ref_fact(10)); end
        bus_read(A_GO, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL pt_go_read got=%h exp=0", v); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            addr    = $urandom;
            if (i % 4 == 0) addr = {28'h000_0080, addr[3:0]};
            in_win  = (addr[31:4] == 28'h000_0080);
            w       = in_win ? 1'b0 : 1'($urandom);
            dmem_rd = $urandom;
            we = w; a = addr; wd = 32'h0;
            #1;
            n_checks++; if (dmem_we !== (w & ~in_win)) begin n_fail++; $display("FAIL pt_rand_we a=%h got=%b exp=%b", addr, dmem_we, w & ~in_win); end
            if (!in_win) begin
                n_checks++; if (rd !== dmem_rd) begin n_fail++; $display("FAIL pt_rand_rd a=%h got=%h exp=%h", addr, rd, dmem_rd); end
            end
            we = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_factorial();
        test_error();
        test_busy_ignore();
        test_passthrough();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
